mem_port_arbiter: RTL and testbench

Shares the single tape-memory port between the per-core select stages (cell fetches) and the per-core write-back paths (cell evictions). Grants at most one access per cycle, round-robin within each class, writes before reads with a starvation bound for reads. Tracks in-flight reads through the memory's fixed 2-cycle read latency and steers returned data back to the requesting core.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Tape-memory port arbiter: one access per cycle, writes favoured over reads
// with a starvation bound, round-robin per class, 2-cycle read return steering.
module mem_port_arbiter #(
    parameter int NCORES       = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        rd_req,
    input  logic [NCORES*ADDR_W-1:0] rd_addr,
    output logic [NCORES-1:0]        rd_gnt,
    output logic [NCORES-1:0]        rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic [NCORES-1:0]        wr_req,
    input  logic [NCORES*ADDR_W-1:0] wr_addr,
    input  logic [NCORES*DATA_W-1:0] wr_data,
    output logic [NCORES-1:0]        wr_gnt,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PTR_W = $clog2(NCORES);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W-1:0] rd_win, wr_win;
    logic [CNT_W-1:0] starve_cnt;
    logic             any_rd, any_wr;
    logic             pick_rd, pick_wr;
    logic             s1_vld;
    logic [PTR_W-1:0] s1_idx;

    // First requester at or above ptr, wrapping modulo NCORES.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NCORES-1:0] req,
                                                 input logic [PTR_W-1:0]  ptr);
        logic [PTR_W-1:0] win;
        logic             found;
        int               idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            idx = (int'(ptr) + i) % NCORES;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] k);
        return (int'(k) == NCORES - 1) ? '0 : k + PTR_W'(1);
    endfunction

    always_comb begin
        any_rd  = |rd_req;
        any_wr  = |wr_req;
        rd_win  = rr_pick(rd_req, rd_ptr);
        wr_win  = rr_pick(wr_req, wr_ptr);
        pick_wr = any_wr && ((starve_cnt < CNT_W'(STARVE_LIMIT)) || !any_rd);
        pick_rd = any_rd && !pick_wr;
    end

    // Outputs are gated by rst so nothing reaches the memory while in reset.
    always_comb begin
        rd_gnt    = '0;
        wr_gnt    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst && pick_wr) begin
            wr_gnt[wr_win] = 1'b1;
            mem_addr       = wr_addr[int'(wr_win)*ADDR_W +: ADDR_W];
            mem_wdata      = wr_data[int'(wr_win)*DATA_W +: DATA_W];
        end else if (!rst && pick_rd) begin
            rd_gnt[rd_win] = 1'b1;
            mem_addr       = rd_addr[int'(rd_win)*ADDR_W +: ADDR_W];
        end
        mem_we  = |wr_gnt;
        mem_en  = (|wr_gnt) | (|rd_gnt);
        rd_data = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            starve_cnt <= '0;
            s1_vld     <= 1'b0;
            s1_idx     <= '0;
            rd_valid   <= '0;
        end else begin
            if (pick_rd) rd_ptr <= ptr_next(rd_win);
            if (pick_wr) wr_ptr <= ptr_next(wr_win);

            if (pick_wr && any_rd) begin
                if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
            end else if (pick_rd || !any_rd) begin
                starve_cnt <= '0;
            end

            // rd_valid acts as the second return stage, decoded to one-hot.
            s1_vld   <= pick_rd;
            s1_idx   <= rd_win;
            rd_valid <= s1_vld ? (NCORES'(1) << s1_idx) : '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-latency memory model.
module tb_mem_port_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    rd_req, rd_gnt, rd_valid, wr_req, wr_gnt;
    logic [NC*AW-1:0] rd_addr, wr_addr;
    logic [NC*DW-1:0] wr_data;
    logic [DW-1:0]    rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_en, mem_we;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.NCORES(NC), .STARVE_LIMIT(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten cells hold a fixed pattern, 0x0010 holds 0x00AB.
    logic [DW-1:0] mem_q  [0:255];
    logic          wr_vld [0:255];
    logic [DW-1:0] p1, p2;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 16'h00AB : 16'h0100 + a;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_q[mem_addr[7:0]]  <= mem_wdata;
            wr_vld[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_en && !mem_we)
            p1 <= (wr_vld[mem_addr[7:0]] === 1'b1) ? mem_q[mem_addr[7:0]] : init_val(mem_addr);
        else
            p1 <= '0;
        p2 <= p1;
    end
    assign mem_rdata = p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        rd_req  = 4'hF;
        wr_req  = 4'hF;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;

        // Reset holds every grant low even with all requests up.
        @(negedge clk);
        chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        tick();
        rd_req = '0;
        wr_req = '0;
        rst    = 1'b0;
        tick();

        // Single read from core 2.
        rd_req = 4'b0100;
        rd_addr[2*AW +: AW] = 16'h0010;
        @(negedge clk);
        chk("t1_rd_gnt", 32'(rd_gnt), 32'h4);
        chk("t1_mem_we", 32'(mem_we), 32'h0);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        tick();
        rd_req = '0;
        @(negedge clk);
        chk("t1_valid_t1", 32'(rd_valid), 32'h0);
        chk("t1_en_t1", 32'(mem_en), 32'h0);
        tick();
        @(negedge clk);
        chk("t1_valid_t2", 32'(rd_valid), 32'h4);
        chk("t1_data_t2", 32'(rd_data), 32'h00AB);
        tick();
        @(negedge clk);
        chk("t1_valid_t3", 32'(rd_valid), 32'h0);
        tick();

        // All four readers held: strict rotation 0,1,2,3,0,1.
        do_reset();
        for (int i = 0; i < NC; i++) rd_addr[i*AW +: AW] = 16'(16'h0020 + i);
        for (int c = 0; c < 8; c++) begin
            rd_req = (c < 6) ? 4'hF : 4'h0;
            @(negedge clk);
            if (c < 6) begin
                chk("rr_rd_gnt", 32'(rd_gnt), 32'(1 << (c % 4)));
                chk("rr_mem_addr", 32'(mem_addr), 32'(16'h0020 + (c % 4)));
            end else begin
                chk("rr_idle_gnt", 32'(rd_gnt), 32'h0);
            end
            if (c >= 2) begin
                chk("rr_rd_valid", 32'(rd_valid), 32'(1 << ((c - 2) % 4)));
                chk("rr_rd_data", 32'(rd_data), 32'(16'h0120 + ((c - 2) % 4)));
            end else begin
                chk("rr_rd_valid_early", 32'(rd_valid), 32'h0);
            end
            tick();
        end

        // Writer 1 vs reader 3: four writes, then the read, then writes again.
        do_reset();
        wr_addr[1*AW +: AW] = 16'h0030;
        wr_data[1*DW +: DW] = 16'h1111;
        rd_addr[3*AW +: AW] = 16'h0040;
        for (int c = 0; c <= 10; c++) begin
            wr_req = 4'b0010;
            rd_req = (c <= 4 || c >= 6) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            if (c == 4 || c == 10) begin
                chk("st_rd_gnt", 32'(rd_gnt), 32'h8);
                chk("st_wr_gnt", 32'(wr_gnt), 32'h0);
                chk("st_rd_addr", 32'(mem_addr), 32'h0040);
            end else begin
                chk("st_wr_gnt", 32'(wr_gnt), 32'h2);
                chk("st_rd_gnt", 32'(rd_gnt), 32'h0);
                chk("st_mem_we", 32'(mem_we), 32'h1);
            end
            if (c == 0) chk("st_wdata", 32'(mem_wdata), 32'h1111);
            tick();
        end
        wr_req = '0;
        rd_req = '0;

        // Write then read of the same cell.
        wr_addr[0*AW +: AW] = 16'h0005;
        wr_data[0*DW +: DW] = 16'h0007;
        wr_req = 4'b0001;
        @(negedge clk);
        chk("wr_gnt", 32'(wr_gnt), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0005);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h0007);
        tick();
        wr_req = '0;
        rd_addr[2*AW +: AW] = 16'h0005;
        rd_req = 4'b0100;
        @(negedge clk);
        chk("raw_rd_gnt", 32'(rd_gnt), 32'h4);
        chk("raw_mem_we", 32'(mem_we), 32'h0);
        tick();
        rd_req = '0;
        tick();
        @(negedge clk);
        chk("raw_valid", 32'(rd_valid), 32'h4);
        chk("raw_data", 32'(rd_data), 32'h0007);
        tick();

        // Reset with a read in flight: the read is dropped, pointers return to 0.
        rd_addr[1*AW +: AW] = 16'h0010;
        rd_addr[3*AW +: AW] = 16'h0040;
        rd_req = 4'b0010;
        @(negedge clk);
        chk("rf_rd_gnt", 32'(rd_gnt), 32'h2);
        tick();
        rd_req = 4'b1010;
        rst    = 1'b1;
        @(negedge clk);
        chk("rf_rst_rd_gnt", 32'(rd_gnt), 32'h0);
        chk("rf_rst_mem_en", 32'(mem_en), 32'h0);
        chk("rf_rst_valid", 32'(rd_valid), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rf_dropped_valid", 32'(rd_valid), 32'h0);
        chk("rf_ptr_zero_gnt", 32'(rd_gnt), 32'h2);
        tick();
        rd_req = '0;
        @(negedge clk);
        chk("rf_valid_t1", 32'(rd_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("rf_valid_t2", 32'(rd_valid), 32'h2);
        chk("rf_data_t2", 32'(rd_data), 32'h00AB);
        tick();

        // Ten idle cycles.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_mem_en", 32'(mem_en), 32'h0);
            chk("idle_mem_addr", 32'(mem_addr), 32'h0);
            chk("idle_gnt", 32'({rd_gnt, wr_gnt}), 32'h0);
            chk("idle_rd_valid", 32'(rd_valid), 32'h0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
